// File: rtl/alarm_pkg.sv
// Shared alarm controller definitions: FSM state codes, BCD digit limits and default timing.
package alarm_pkg;

   localparam int unsigned BcdDigitMax      = 9;
   localparam int unsigned BcdZMinMax       = 5;
   localparam int unsigned HourMax          = 23;
   localparam int unsigned RingMinDefault   = 5;
   localparam int unsigned SnoozeMinDefault = 9;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StArmed   = 2'd1;
   localparam logic [1:0] StRinging = 2'd2;
   localparam logic [1:0] StSnoozed = 2'd3;

   function automatic logic timeValid(input logic [3:0] uMin, input logic [2:0] zMin,
                                      input logic [3:0] uHour, input logic [1:0] zHour);
      logic hourOk;
      hourOk = (zHour < 2'(HourMax / 10) && uHour <= 4'(BcdDigitMax)) ||
               (zHour == 2'(HourMax / 10) && uHour <= 4'(HourMax % 10));
      return (uMin <= 4'(BcdDigitMax)) && (zMin <= 3'(BcdZMinMax)) && hourOk;
   endfunction

endpackage

// File: rtl/bcd_time_add.sv
// Combinational BCD hh:mm plus a constant minute offset (0..9), wrapping 59->00 and 23->00.
module bcd_time_add
   import alarm_pkg::*;
#(
   parameter int unsigned ADD_MIN = SnoozeMinDefault
) (
   input  logic [3:0] uMin,
   input  logic [2:0] zMin,
   input  logic [3:0] uHour,
   input  logic [1:0] zHour,
   output logic [3:0] uMinOut,
   output logic [2:0] zMinOut,
   output logic [3:0] uHourOut,
   output logic [1:0] zHourOut
);

   logic [4:0] uSum;
   logic       carryMin;
   logic       carryHour;

   always_comb begin
      uSum      = {1'b0, uMin} + 5'(ADD_MIN);
      carryMin  = 1'b0;
      carryHour = 1'b0;
      uMinOut   = uSum[3:0];
      zMinOut   = zMin;
      uHourOut  = uHour;
      zHourOut  = zHour;
      if (uSum > 5'(BcdDigitMax)) begin
         uMinOut  = 4'(uSum - 5'd10);
         carryMin = 1'b1;
      end
      if (carryMin) begin
         if (zMin >= 3'(BcdZMinMax)) begin
            zMinOut   = 3'd0;
            carryHour = 1'b1;
         end else begin
            zMinOut = zMin + 3'd1;
         end
      end
      if (carryHour) begin
         if (zHour == 2'(HourMax / 10) && uHour == 4'(HourMax % 10)) begin
            uHourOut = 4'd0;
            zHourOut = 2'd0;
         end else if (uHour >= 4'(BcdDigitMax)) begin
            uHourOut = 4'd0;
            zHourOut = zHour + 2'd1;
         end else begin
            uHourOut = uHour + 4'd1;
         end
      end
   end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: programmable BCD alarm, edge-triggered ring with timeout.
// Optional snooze path enabled by defining ALARM_SNOOZE_EN.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int unsigned RING_MIN   = RingMinDefault,
   parameter int unsigned SNOOZE_MIN = SnoozeMinDefault
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sel_program,
   input  logic [3:0] u_min_set,
   input  logic [2:0] z_min_set,
   input  logic [3:0] u_hour_set,
   input  logic [1:0] z_hour_set,
   input  logic [3:0] u_min_in,
   input  logic [2:0] z_min_in,
   input  logic [3:0] u_hour_in,
   input  logic [1:0] z_hour_in,
   input  logic       alarm_en,
   input  logic       stop,
   input  logic       snooze,
   output logic       ring,
   output logic       armed,
   output logic [3:0] u_min_alm,
   output logic [2:0] z_min_alm,
   output logic [3:0] u_hour_alm,
   output logic [1:0] z_hour_alm,
   output logic       prog_err
);

   localparam logic [5:0] RingLoad = 6'(RING_MIN);

   logic [1:0]  stateQ, stateD;
   logic [5:0]  cntQ, cntD;
   logic        matchPrevQ, match, trigger, progValid, snoozeReq;
   logic [12:0] curTime, almQ, target;

   assign curTime   = {z_hour_in, u_hour_in, z_min_in, u_min_in};
   assign progValid = sel_program && timeValid(u_min_set, z_min_set, u_hour_set, z_hour_set);
   assign match     = (curTime == target);
   // Rising edge of match only, so a silenced alarm stays quiet for the rest of its minute.
   assign trigger   = match && !matchPrevQ && !progValid;

`ifdef ALARM_SNOOZE_EN
   logic [12:0] snzQ, snzSum;

   bcd_time_add #(
      .ADD_MIN(SNOOZE_MIN)
   ) uSnoozeAdd (
      .uMin    (u_min_in),
      .zMin    (z_min_in),
      .uHour   (u_hour_in),
      .zHour   (z_hour_in),
      .uMinOut (snzSum[3:0]),
      .zMinOut (snzSum[6:4]),
      .uHourOut(snzSum[10:7]),
      .zHourOut(snzSum[12:11])
   );

   assign target    = (stateQ == StSnoozed) ? snzQ : almQ;
   assign snoozeReq = snooze;

   always_ff @(posedge clk) begin
      if (rst) begin
         snzQ <= '0;
      end else if (stateQ == StRinging && stateD == StSnoozed) begin
         snzQ <= snzSum;
      end
   end
`else
   logic [4:0] unusedCfg;
   assign unusedCfg = {snooze, 4'(SNOOZE_MIN)};
   assign target    = almQ;
   assign snoozeReq = 1'b0;
`endif

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      case (stateQ)
         StIdle: begin
            if (alarm_en) stateD = StArmed;
         end
         StArmed: begin
            if (trigger) begin
               stateD = StRinging;
               cntD   = RingLoad;
            end
         end
         StRinging: begin
            cntD = cntQ - 6'd1;
            if (stop) begin
               stateD = StArmed;
               cntD   = '0;
            end else if (snoozeReq) begin
               stateD = StSnoozed;
               cntD   = '0;
            end else if (cntQ <= 6'd1) begin
               stateD = StArmed;
               cntD   = '0;
            end
         end
         StSnoozed: begin
            if (stop) begin
               stateD = StArmed;
            end else if (trigger) begin
               stateD = StRinging;
               cntD   = RingLoad;
            end
         end
         default: stateD = StIdle;
      endcase
      if (progValid && (stateQ == StRinging || stateQ == StSnoozed)) begin
         stateD = StArmed;
         cntD   = '0;
      end
      if (!alarm_en) begin
         stateD = StIdle;
         cntD   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ     <= StIdle;
         cntQ       <= '0;
         matchPrevQ <= 1'b1;
         almQ       <= '0;
         ring       <= 1'b0;
         prog_err   <= 1'b0;
      end else begin
         stateQ     <= stateD;
         cntQ       <= cntD;
         matchPrevQ <= match;
         ring       <= (stateD == StRinging);
         prog_err   <= sel_program && !progValid;
         if (progValid) almQ <= {z_hour_set, u_hour_set, z_min_set, u_min_set};
      end
   end

   assign armed = (stateQ != StIdle);
   assign {z_hour_alm, u_hour_alm, z_min_alm, u_min_alm} = almQ;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: expected outputs queued per driven cycle, checked after the edge.
module tb_alarm_ctrl;
   import alarm_pkg::*;

   logic       clk = 1'b0;
   logic       rst, sel_program, alarm_en, stop, snooze;
   logic [3:0] u_min_set, u_hour_set, u_min_in, u_hour_in;
   logic [2:0] z_min_set, z_min_in;
   logic [1:0] z_hour_set, z_hour_in;
   logic       ring, armed, prog_err;
   logic [3:0] u_min_alm, u_hour_alm;
   logic [2:0] z_min_alm;
   logic [1:0] z_hour_alm;

   typedef struct {
      string       tag;
      logic        ring;
      logic        armed;
      logic        err;
      logic [12:0] alm;
   } exp_t;

   exp_t        sbQueue[$];
   logic [12:0] expAlm;
   int          nTests = 0;
   int          nFail  = 0;

   alarm_ctrl #(
      .RING_MIN  (5),
      .SNOOZE_MIN(9)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sel_program(sel_program),
      .u_min_set  (u_min_set),
      .z_min_set  (z_min_set),
      .u_hour_set (u_hour_set),
      .z_hour_set (z_hour_set),
      .u_min_in   (u_min_in),
      .z_min_in   (z_min_in),
      .u_hour_in  (u_hour_in),
      .z_hour_in  (z_hour_in),
      .alarm_en   (alarm_en),
      .stop       (stop),
      .snooze     (snooze),
      .ring       (ring),
      .armed      (armed),
      .u_min_alm  (u_min_alm),
      .z_min_alm  (z_min_alm),
      .u_hour_alm (u_hour_alm),
      .z_hour_alm (z_hour_alm),
      .prog_err   (prog_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [12:0] bcd(input int h, input int m);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
   endfunction

   task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic setTime(input int h, input int m);
      {z_hour_in, u_hour_in, z_min_in, u_min_in} = bcd(h, m);
   endtask

   task automatic setProg(input int h, input int m);
      {z_hour_set, u_hour_set, z_min_set, u_min_set} = bcd(h, m);
   endtask

   // Push the expectation for the edge about to happen, then compare just after it.
   task automatic cycle(input string tag, input logic eRing, input logic eArmed, input logic eErr);
      exp_t e;
      e.tag = tag; e.ring = eRing; e.armed = eArmed; e.err = eErr; e.alm = expAlm;
      sbQueue.push_back(e);
      @(posedge clk);
      #1;
      e = sbQueue.pop_front();
      checkVal({e.tag, ".ring"}, 16'(ring), 16'(e.ring));
      checkVal({e.tag, ".armed"}, 16'(armed), 16'(e.armed));
      checkVal({e.tag, ".prog_err"}, 16'(prog_err), 16'(e.err));
      checkVal({e.tag, ".alm"}, 16'({z_hour_alm, u_hour_alm, z_min_alm, u_min_alm}), 16'(e.alm));
   endtask

   initial begin
      rst = 1'b1; sel_program = 1'b0; alarm_en = 1'b0; stop = 1'b0; snooze = 1'b0;
      setTime(0, 0); setProg(0, 0); expAlm = '0;
      cycle("reset", 1'b0, 1'b0, 1'b0);
      cycle("reset_hold", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // Program 06:30 and ring for the full duration.
      sel_program = 1'b1; setProg(6, 30); setTime(6, 0); expAlm = bcd(6, 30);
      cycle("prog_0630", 1'b0, 1'b0, 1'b0);
      sel_program = 1'b0; alarm_en = 1'b1; setTime(6, 29);
      cycle("arm", 1'b0, 1'b1, 1'b0);
      setTime(6, 30);
      cycle("ring_start", 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle("ring_hold", 1'b1, 1'b1, 1'b0);
      cycle("ring_timeout", 1'b0, 1'b1, 1'b0);
      cycle("no_rering", 1'b0, 1'b1, 1'b0);

      // Stop held during the matching minute.
      setTime(6, 29);
      cycle("pre_0630", 1'b0, 1'b1, 1'b0);
      setTime(6, 30);
      cycle("ring_again", 1'b1, 1'b1, 1'b0);
      stop = 1'b1;
      cycle("stop", 1'b0, 1'b1, 1'b0);
      cycle("stop_hold", 1'b0, 1'b1, 1'b0);
      stop = 1'b0;
      cycle("stay_quiet", 1'b0, 1'b1, 1'b0);

      // Reprogram, then two rejected attempts.
      sel_program = 1'b1; setProg(23, 55); setTime(6, 31); expAlm = bcd(23, 55);
      cycle("prog_2355", 1'b0, 1'b1, 1'b0);
      setProg(24, 0);
      cycle("bad_hour", 1'b0, 1'b1, 1'b1);
      sel_program = 1'b0;
      cycle("err_clear", 1'b0, 1'b1, 1'b0);
      sel_program = 1'b1; setProg(12, 60);
      cycle("bad_zmin", 1'b0, 1'b1, 1'b1);
      sel_program = 1'b0;
      cycle("err_clear2", 1'b0, 1'b1, 1'b0);

      // Snooze across midnight (or ignored snooze when the feature is absent).
      setTime(23, 54);
      cycle("pre_2355", 1'b0, 1'b1, 1'b0);
      setTime(23, 55);
      cycle("ring_2355", 1'b1, 1'b1, 1'b0);
`ifdef ALARM_SNOOZE_EN
      snooze = 1'b1;
      cycle("snooze", 1'b0, 1'b1, 1'b0);
      snooze = 1'b0; setTime(0, 3);
      cycle("snoozed_0003", 1'b0, 1'b1, 1'b0);
      setTime(0, 4);
      cycle("snooze_ring_0004", 1'b1, 1'b1, 1'b0);
      stop = 1'b1;
      cycle("snooze_stop", 1'b0, 1'b1, 1'b0);
      stop = 1'b0;
`else
      snooze = 1'b1;
      for (int i = 0; i < 4; i++) cycle("snooze_ignored", 1'b1, 1'b1, 1'b0);
      cycle("snooze_timeout", 1'b0, 1'b1, 1'b0);
      snooze = 1'b0;
`endif

      // Disarm while ringing, then re-arm inside the same minute.
      setTime(23, 54);
      cycle("pre_disarm", 1'b0, 1'b1, 1'b0);
      setTime(23, 55);
      cycle("ring_disarm", 1'b1, 1'b1, 1'b0);
      alarm_en = 1'b0;
      cycle("disarm", 1'b0, 1'b0, 1'b0);
      alarm_en = 1'b1;
      cycle("rearm", 1'b0, 1'b1, 1'b0);
      cycle("rearm_no_ring", 1'b0, 1'b1, 1'b0);

      // Valid program while ringing returns to armed.
      setTime(23, 54);
      cycle("pre_prog", 1'b0, 1'b1, 1'b0);
      setTime(23, 55);
      cycle("ring_prog", 1'b1, 1'b1, 1'b0);
      sel_program = 1'b1; setProg(7, 0); expAlm = bcd(7, 0);
      cycle("prog_in_ring", 1'b0, 1'b1, 1'b0);
      sel_program = 1'b0;

      // Reset while ringing.
      setTime(6, 59);
      cycle("pre_0700", 1'b0, 1'b1, 1'b0);
      setTime(7, 0);
      cycle("ring_0700", 1'b1, 1'b1, 1'b0);
      rst = 1'b1; expAlm = '0;
      cycle("rst_in_ring", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cycle("post_rst", 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_MIN, default 5, meaning ring duration in clk ticks (one tick = one minute), legal 1..59.
REQ-002 SHALL have parameter SNOOZE_MIN, default 9, meaning snooze offset in minutes, legal 1..9.
REQ-003 clk  in  1  time-base clock, one rising edge per minute tick, same clock as the upstream time counter.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 sel_program  in  1  load alarm time from *_set inputs this cycle.
REQ-006 u_min_set [3:0], z_min_set [2:0], u_hour_set [3:0], z_hour_set [1:0]  in  alarm time to program, BCD.
REQ-007 u_min_in [3:0], z_min_in [2:0], u_hour_in [3:0], z_hour_in [1:0]  in  current time from the upstream counter, BCD.
REQ-008 alarm_en  in  1  arm alarm (level).
REQ-009 stop  in  1  silence alarm (level, sampled per cycle).
REQ-010 snooze  in  1  snooze request (level, sampled per cycle).
REQ-011 ring  out  1  registered buzzer drive.
REQ-012 armed  out  1  high in ARMED, RINGING, SNOOZED.
REQ-013 u_min_alm [3:0], z_min_alm [2:0], u_hour_alm [3:0], z_hour_alm [1:0]  out  stored alarm time, for display.
REQ-014 prog_err  out  1  one-cycle pulse on rejected program attempt.

Function
REQ-015 FSM states SHALL be IDLE, ARMED, RINGING, SNOOZED; ring=1 only in RINGING.
REQ-016 match SHALL be current time == target, target = alarm register in ARMED, snooze register in SNOOZED.
REQ-017 Trigger SHALL be match rising edge only (match now, not match previous cycle), so a stopped alarm does not re-ring within the same minute.
REQ-018 IDLE->ARMED when alarm_en=1; any state->IDLE when alarm_en=0 (highest priority, ring=0 next cycle).
REQ-019 ARMED->RINGING on trigger; ring rises one clk after the matching time is presented.
REQ-020 RINGING SHALL load ring counter with RING_MIN on entry, decrement per clk, go to ARMED when it reaches 0 (ring high exactly RING_MIN cycles).
REQ-021 RINGING priority: alarm_en=0 > stop (->ARMED) > snooze (->SNOOZED) > timeout (->ARMED).
REQ-022 On snooze, snooze register SHALL capture current time + SNOOZE_MIN in BCD, minutes wrap 59->00 with hour carry, 23:xx wraps to 00:xx.
REQ-023 SNOOZED->RINGING on trigger (counter reloaded); stop -> ARMED.
REQ-024 sel_program with all digits valid (u<=9, z_min<=5, hour<=23) SHALL load alarm register next cycle; RINGING/SNOOZED SHALL go to ARMED; trigger suppressed that cycle.
REQ-025 Invalid program SHALL leave alarm register unchanged and pulse prog_err one cycle.
REQ-026 stop and snooze in IDLE/ARMED SHALL have no effect.

Reset
REQ-027 rst SHALL force state IDLE, ring=0, armed=0, prog_err=0, alarm and snooze registers 00:00, ring counter 0, match history 1 (no trigger on first post-reset cycle).
REQ-028 rst asserted mid-RINGING SHALL drop ring on the next clk edge.

Configuration
REQ-029 Macro ALARM_SNOOZE_EN: defined -> snooze path per REQ-021..023; undefined -> snooze input ignored, SNOOZED unreachable, snooze register and adder not built.

Structure
REQ-030 Package alarm_pkg SHALL hold state enum, BCD digit max constants (9, 5, 23) and RING_MIN/SNOOZE_MIN defaults.
REQ-031 Sub-module bcd_time_add SHALL compute the combinational BCD time + minutes with wrap.

Verification
REQ-032 Program 06:30, alarm_en=1, feed 06:29->06:30 -> ring=1 from the next clk for 5 cycles, then 0, armed=1.
REQ-033 Ringing at 06:30, stop=1 during 06:30 held twice -> ring=0 next clk, no re-ring while 06:30 persists.
REQ-034 Ringing at 23:55, snooze=1 -> SNOOZED, ring=0; at 00:04 -> ring=1 (wrap check).
REQ-035 sel_program with 24:00 or z_min_set=6 -> prog_err one pulse, u/z_*_alm unchanged.
REQ-036 rst during RINGING -> ring=0, armed=0, alarm outputs 00:00 after one clk.
REQ-037 Build without ALARM_SNOOZE_EN, snooze=1 while ringing -> ring continues to RING_MIN timeout.
